// File: rtl/z80_mem_responder_if.sv
// rtl/z80_mem_responder_if.sv - core memory bus and slow external port bundle
//
// Signals, with direction as seen from the responder (slave modport):
//   A       in   16  address from the core
//   DO      in    8  write data from the core
//   W       in    1  write strobe from the core
//   DI      out   8  registered read data to the core
//   HOLD    out   1  1 = core runs, 0 = core frozen
//   EXT_A   out  16  latched external address
//   EXT_DO  out   8  latched external write data
//   EXT_WE  out   1  external access is a write
//   EXT_REQ out   1  external request, held until acknowledged
//   EXT_DI  in    8  external read data, valid with EXT_ACK
//   EXT_ACK in    1  external completion
// The master modport is the opposite end: the core plus the external device.
interface z80_mem_responder_if;
  logic [15:0] A;
  logic [7:0]  DO;
  logic        W;
  logic [7:0]  DI;
  logic        HOLD;
  logic [15:0] EXT_A;
  logic [7:0]  EXT_DO;
  logic        EXT_WE;
  logic        EXT_REQ;
  logic [7:0]  EXT_DI;
  logic        EXT_ACK;

  modport master (
    output A, DO, W, EXT_DI, EXT_ACK,
    input  DI, HOLD, EXT_A, EXT_DO, EXT_WE, EXT_REQ
  );

  modport slave (
    input  A, DO, W, EXT_DI, EXT_ACK,
    output DI, HOLD, EXT_A, EXT_DO, EXT_WE, EXT_REQ
  );
endinterface

// File: rtl/z80_mem_responder.sv
// rtl/z80_mem_responder.sv - z80 bus target: internal RAM plus stalled external window
//
// Ports:
//   CLOCK    in   system clock, rising edge
//   RESET    in   asynchronous active-high reset
//   bus      slave modport of z80_mem_responder_if (core bus and external port)
//   ROM_WV   out  sticky: a write hit the protected low window
//   EXT_ERR  out  sticky: an external access timed out
// Build option: define Z80MEM_ROMWP_EN to block writes at A <= ROM_TOP and
// flag them on ROM_WV; otherwise all internal addresses are writable and
// ROM_WV is tied low.
module z80_mem_responder #(
  parameter int          RAM_AW      = 14,
  parameter logic [15:0] ROM_TOP     = 16'h3FFF,
  parameter logic [15:0] EXT_BASE    = 16'hC000,
  parameter int          EXT_TIMEOUT = 15
) (
  input  logic               CLOCK,
  input  logic               RESET,
  z80_mem_responder_if.slave bus,
  output logic               ROM_WV,
  output logic               EXT_ERR
);

  localparam int CW = (EXT_TIMEOUT < 1) ? 1 : $clog2(EXT_TIMEOUT + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RELEASE, ST_ERR} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [7:0]         mem [0:(1<<RAM_AW)-1];

  logic               is_ext;
  logic               wr_prot;
  logic               mem_we;
  logic [RAM_AW-1:0]  ram_idx;

  assign is_ext  = (bus.A >= EXT_BASE);
  // RAM is mirrored across the whole internal range.
  assign ram_idx = bus.A[RAM_AW-1:0];

`ifdef Z80MEM_ROMWP_EN
  assign wr_prot = (bus.A <= ROM_TOP);
`else
  // Protection compiled out; ROM_TOP has no effect in this build.
  assign wr_prot = 1'b0 & (bus.A <= ROM_TOP);
`endif

  assign mem_we = bus.W && !is_ext && !wr_prot;

  // RAM array carries no reset so its contents survive RESET.
  always_ff @(posedge CLOCK) begin
    if (mem_we) mem[ram_idx] <= bus.DO;
  end

`ifdef Z80MEM_ROMWP_EN
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      ROM_WV <= 1'b0;
    end else if (bus.W && !is_ext && wr_prot) begin
      ROM_WV <= 1'b1;
    end
  end
`else
  assign ROM_WV = 1'b0;
`endif

  // DI is read-first: the read here sees the byte before any same-edge write.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      bus.DI      <= 8'h00;
      bus.HOLD    <= 1'b1;
      bus.EXT_REQ <= 1'b0;
      bus.EXT_WE  <= 1'b0;
      bus.EXT_A   <= 16'h0000;
      bus.EXT_DO  <= 8'h00;
      EXT_ERR     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (is_ext) begin
            bus.EXT_A   <= bus.A;
            bus.EXT_DO  <= bus.DO;
            bus.EXT_WE  <= bus.W;
            bus.EXT_REQ <= 1'b1;
            bus.HOLD    <= 1'b0;
            cnt         <= CW'(EXT_TIMEOUT);
            state       <= ST_REQ;
          end else begin
            bus.DI <= mem[ram_idx];
          end
        end
        ST_REQ: begin
          // ACK is tested first so it wins over a coincident expiry.
          if (bus.EXT_ACK) begin
            if (!bus.EXT_WE) bus.DI <= bus.EXT_DI;
            bus.EXT_REQ <= 1'b0;
            bus.HOLD    <= 1'b1;
            state       <= ST_RELEASE;
          end else if (cnt == '0) begin
            bus.DI      <= 8'hFF;
            bus.EXT_REQ <= 1'b0;
            bus.HOLD    <= 1'b1;
            EXT_ERR     <= 1'b1;
            state       <= ST_ERR;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_RELEASE, ST_ERR: begin
          // The core still shows the finished external address this cycle;
          // ignore it so the access is not re-issued.
          if (!is_ext) bus.DI <= mem[ram_idx];
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_z80_mem_responder.sv
// tb/tb_z80_mem_responder.sv - directed self-checking bench for z80_mem_responder
module tb_z80_mem_responder;
  logic CLOCK = 1'b0;
  logic RESET;
  logic ROM_WV;
  logic EXT_ERR;

  z80_mem_responder_if bus ();

  z80_mem_responder dut (
    .CLOCK   (CLOCK),
    .RESET   (RESET),
    .bus     (bus),
    .ROM_WV  (ROM_WV),
    .EXT_ERR (EXT_ERR)
  );

  always #5 CLOCK = ~CLOCK;

  int errors = 0;
  int checks = 0;
  int hold_low_cnt = 0;
  int req_rise_cnt = 0;
  logic req_prev = 1'b0;

  // Cycle counters sampled mid-cycle, away from the active edge.
  always @(negedge CLOCK) begin
    if (bus.HOLD === 1'b0) hold_low_cnt <= hold_low_cnt + 1;
    if (bus.EXT_REQ === 1'b1 && req_prev !== 1'b1) req_rise_cnt <= req_rise_cnt + 1;
    req_prev <= bus.EXT_REQ;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  // Runs one external access; k = cycles before ACK rises (-1: never).
  task automatic ext_access(input logic [15:0] addr, input logic [7:0] data,
                            input logic we, input int k, input logic [7:0] xdi,
                            output int hold_low, output int req_rises,
                            output logic [7:0] di_out);
    int h0, r0, n;
    h0 = hold_low_cnt;
    r0 = req_rise_cnt;
    bus.A = addr; bus.DO = data; bus.W = we; bus.EXT_DI = xdi;
    tick();
    check("ext_req_up", bus.EXT_REQ, 1);
    check("ext_a", bus.EXT_A, addr);
    check("ext_we", bus.EXT_WE, we);
    if (we) check("ext_do", bus.EXT_DO, data);
    n = 0;
    while (bus.HOLD === 1'b0 && n < 40) begin
      bus.EXT_ACK = (k >= 0 && n >= k);
      tick();
      n++;
    end
    bus.EXT_ACK = 1'b0;
    check("ext_done", bus.HOLD, 1);
    di_out = bus.DI;
    tick();
    bus.A = 16'h4000; bus.W = 1'b0;
    tick();
    tick();
    hold_low  = hold_low_cnt - h0;
    req_rises = req_rise_cnt - r0;
  endtask

  int hl, rr;
  logic [7:0] di;

  initial begin
    RESET = 1'b1;
    bus.A = 16'h0000; bus.DO = 8'h00; bus.W = 1'b0;
    bus.EXT_DI = 8'h00; bus.EXT_ACK = 1'b0;
    tick(); tick();
    check("rst_di", bus.DI, 8'h00);
    check("rst_hold", bus.HOLD, 1);
    check("rst_req", bus.EXT_REQ, 0);
    check("rst_ext_a", bus.EXT_A, 16'h0000);
    check("rst_romwv", ROM_WV, 0);
    check("rst_exterr", EXT_ERR, 0);
    RESET = 1'b0;

    // Internal write then read; read-first on a same-edge write.
    bus.A = 16'h4000; bus.DO = 8'h5A; bus.W = 1'b1; tick();
    bus.W = 1'b0; tick();
    check("ram_rd_5a", bus.DI, 8'h5A);
    bus.DO = 8'h77; bus.W = 1'b1; tick();
    check("ram_rd_first", bus.DI, 8'h5A);
    bus.W = 1'b0; tick();
    check("ram_rd_77", bus.DI, 8'h77);
    check("int_hold", bus.HOLD, 1);

    // Seed index 0x0010 via its writable mirror, then try the ROM window.
    bus.A = 16'h4010; bus.DO = 8'h11; bus.W = 1'b1; tick();
    bus.A = 16'h0010; bus.DO = 8'hAA; tick();
    bus.W = 1'b0; tick();
`ifdef Z80MEM_ROMWP_EN
    check("rom_byte", bus.DI, 8'h11);
    check("rom_wv", ROM_WV, 1);
`else
    check("rom_byte", bus.DI, 8'hAA);
    check("rom_wv", ROM_WV, 0);
`endif

    // External read, ACK three cycles after request.
    ext_access(16'hC123, 8'h00, 1'b0, 3, 8'h3C, hl, rr, di);
    check("rd_hold_low", hl, 4);
    check("rd_req_pulses", rr, 1);
    check("rd_di", di, 8'h3C);

    // ACK on the same edge as counter expiry.
    ext_access(16'hC000, 8'h00, 1'b0, 15, 8'h42, hl, rr, di);
    check("coin_hold_low", hl, 16);
    check("coin_di", di, 8'h42);
    check("coin_err", EXT_ERR, 0);

    // External write that is never acknowledged.
    ext_access(16'hFFFF, 8'h99, 1'b1, -1, 8'h00, hl, rr, di);
    check("to_hold_low", hl, 16);
    check("to_req_pulses", rr, 1);
    check("to_di", di, 8'hFF);
    check("to_err", EXT_ERR, 1);

    // Next access after a timeout, minimum stall.
    ext_access(16'hD000, 8'h00, 1'b0, 0, 8'h5E, hl, rr, di);
    check("min_hold_low", hl, 1);
    check("min_di", di, 8'h5E);

    // Reset in the middle of a request.
    bus.A = 16'h4020; bus.DO = 8'h5C; bus.W = 1'b1; tick();
    bus.W = 1'b0; bus.A = 16'hC000; tick(); tick();
    check("pre_rst_req", bus.EXT_REQ, 1);
    #2 RESET = 1'b1;
    #1;
    check("mid_rst_req", bus.EXT_REQ, 0);
    check("mid_rst_hold", bus.HOLD, 1);
    bus.A = 16'h4020;
    tick();
    RESET = 1'b0;
    check("post_rst_di", bus.DI, 8'h00);
    check("post_rst_err", EXT_ERR, 0);
    check("post_rst_romwv", ROM_WV, 0);
    tick();
    check("post_rst_ram", bus.DI, 8'h5C);
    check("post_rst_idle", bus.EXT_REQ, 0);
    check("post_rst_run", bus.HOLD, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/z80_mem_responder.md
# z80_mem_responder

Bus responder for the z80 core: the target end of its single-cycle memory bus (A, DO, W out of the core; DI, HOLD into it). It serves internal synchronous RAM with one-cycle registered read data and blocks writes to the low ROM window. It forwards the upper address window to a slow external request/acknowledge port, stalling the core through HOLD until the access completes or times out.

## Interface

Port names follow the core's view: DO and W come from the core, DI and HOLD go to it.

**Parameters**
- RAM_AW, 14: internal RAM address width. Size is 2^RAM_AW bytes, indexed by A[RAM_AW-1:0] and mirrored below EXT_BASE.
- ROM_TOP, 16'h3FFF: writes with A <= ROM_TOP are write-protected.
- EXT_BASE, 16'hC000: addresses with A >= EXT_BASE go to the external port.
- EXT_TIMEOUT, 15: maximum cycles the block waits for EXT_ACK.

**Ports**
- CLOCK  in  1  system clock, rising edge. One clock only.
- RESET  in  1  asynchronous, active-high reset.
- A  in  16  address from the core.
- DO  in  8  write data from the core.
- W  in  1  write strobe from the core.
- DI  out  8  registered read data to the core.
- HOLD  out  1  1 = core runs, 0 = core frozen.
- EXT_A  out  16  latched external address.
- EXT_DO  out  8  latched external write data.
- EXT_WE  out  1  external access is a write.
- EXT_REQ  out  1  external request, held high until acknowledged.
- EXT_DI  in  8  external read data, valid with EXT_ACK.
- EXT_ACK  in  1  external completion, sampled on the rising edge.
- ROM_WV  out  1  sticky flag: write to the protected window occurred.
- EXT_ERR  out  1  sticky flag: external timeout occurred.

## Operation

- Decode on every cycle:
  - external when A >= EXT_BASE;
  - internal otherwise.
- Internal read: DI <= mem[A[RAM_AW-1:0]] on every rising edge, read-first. A same-cycle write to the same address returns the old byte.
- Internal write: when W=1, A > ROM_TOP and A is internal, mem <= DO at the edge.
- Protected write: when W=1 and A <= ROM_TOP, memory is unchanged and ROM_WV <= 1 (sticky until reset).
- External FSM has four states: IDLE, REQ, RELEASE, ERR.
- IDLE:
  - On an external decode, latch EXT_A=A, EXT_DO=DO, EXT_WE=W.
  - Set EXT_REQ=1 and HOLD=0; load the timeout counter with EXT_TIMEOUT; go to REQ.
  - DI keeps its previous value.
  - EXT_ACK is ignored in IDLE.
- REQ:
  - Counter decrements each cycle.
  - EXT_ACK=1: DI <= EXT_DI on reads (DI unchanged on writes), EXT_REQ <= 0, HOLD <= 1, go to RELEASE.
  - Counter reaches 0 without ACK: DI <= 8'hFF, EXT_REQ <= 0, EXT_ERR <= 1, HOLD <= 1, go to ERR.
  - ACK and counter expiry on the same edge: ACK wins.
- RELEASE / ERR:
  - One cycle, then IDLE.
  - The still-presented external decode is ignored, so the same access is never re-issued.
- Reset mid-transaction:
  - EXT_REQ drops immediately; HOLD returns to 1; FSM returns to IDLE.
  - RAM contents are preserved.

## Timing

- Reset values:
  - DI=8'h00, HOLD=1, EXT_REQ=0, EXT_WE=0, EXT_A=16'h0000, EXT_DO=8'h00.
  - ROM_WV=0, EXT_ERR=0, FSM=IDLE, counter=0.
  - RAM is not cleared.
- Internal read latency is 1 cycle: A presented before edge n gives DI valid after edge n. This matches the core's d0 <= DI pipeline.
- Internal write takes effect at the edge where W=1; no stall.
- External access, ACK arriving k cycles after EXT_REQ rises:
  - HOLD is low for k+1 cycles, from the edge after detect through the ACK edge inclusive.
  - DI is valid after the ACK edge.
- Minimum external stall (ACK already high in the first REQ cycle): HOLD low for 1 cycle.
- Timeout stall: HOLD low for EXT_TIMEOUT+1 cycles.
- Back-to-back external accesses need at least one RELEASE cycle between requests.

## Configuration

- Macro: Z80MEM_ROMWP_EN.
- Defined:
  - Protected-write blocking and ROM_WV behave as described above.
- Undefined:
  - Every internal address is writable.
  - ROM_WV is tied to 0.
  - ROM_TOP is unused.

## Test plan

- Reset asserted mid-REQ → EXT_REQ=0 and HOLD=1 immediately. After release: DI=00, flags 0, FSM idle. A RAM byte written before the reset still reads back its value.
- Write 8'h5A to 16'h4000, then read 16'h4000 → DI=5A one cycle after the read address. A simultaneous write of 8'h77 and read of the same address returns 5A; the next read returns 77.
- W=1, A=16'h0010, DO=8'hAA:
  - With macro defined: byte at 0010 unchanged, ROM_WV=1.
  - Without macro: byte becomes AA, ROM_WV=0.
- External read at 16'hC123 with ACK after 3 cycles and EXT_DI=8'h3C → EXT_A=C123, EXT_WE=0, HOLD low 4 cycles, DI=3C, exactly one EXT_REQ pulse.
- External write at 16'hFFFF with DO=8'h99 and ACK never asserted → EXT_DO=99, EXT_WE=1, HOLD low 16 cycles, DI=FF, EXT_ERR=1. Next access behaves normally.
- ACK coincident with counter expiry, EXT_DI=8'h42 → DI=42, EXT_ERR stays 0.
